// File: rtl/display_pkg.sv
// Shared display-pipeline definitions: sprite layer indices, widths and
// the special colour values used by the layer compositor.
package display_pkg;

  localparam int N_REQ         = 4;
  localparam int REQ_ATTACK    = 0;
  localparam int REQ_PLAYER    = 1;
  localparam int REQ_MONSTER0  = 2;
  localparam int REQ_ITEM      = 3;

  localparam int SPRITE_ADDR_W = 14;
  localparam int PIXEL_W       = 12;

  localparam logic [PIXEL_W-1:0] TRANSPARENT = 12'hCBE;
  localparam logic [PIXEL_W-1:0] BLACK       = 12'h000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester at or after the
// pointer (wrapping modulo N_REQ) wins. Wrap is explicit so non-power-of-two
// requester counts work.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  logic [PTR_W:0] cand;

  // Scan N_REQ slots starting at ptr; the first set request becomes the one-hot grant
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N_REQ)) begin
        cand = cand - (PTR_W+1)'(N_REQ);
      end
      if (!found && req[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[PTR_W-1:0];
      end
    end
    if (found) begin
      gnt = N_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous-read sprite ROM among the sprite layers. Grants
// are combinational; the ROM port, return strobe and data are registered.
// A one-hot tag pipeline tracks which layer each in-flight read belongs to,
// and a per-frame conflict counter reports how often layers collided.
module sprite_rom_arbiter #(
  parameter int N_REQ   = display_pkg::N_REQ,
  parameter int ADDR_W  = display_pkg::SPRITE_ADDR_W,
  parameter int DATA_W  = display_pkg::PIXEL_W,
  parameter int ROM_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [15:0]             stat_conflicts
);

  import display_pkg::*;

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic [N_REQ-1:0]              pick_gnt;
  logic [PTR_W-1:0]              pick_idx;
  logic                          pick_found;

  logic                          rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]             rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0][N_REQ-1:0]   tag_q, tag_d;
  logic [N_REQ-1:0]              rvalid_q, rvalid_d;
  logic [DATA_W-1:0]             rdata_q, rdata_d;

  logic                          conflict;
  logic [15:0]                   run_inc;
  logic [15:0]                   run_q, run_d;
  logic [15:0]                   stat_q, stat_d;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Grant is suppressed while reset is held so no layer thinks it was served
  assign gnt = rst_n ? pick_gnt : '0;

  // Next-state for pointer, ROM port, tag pipeline, return path and conflict stats
  always_comb begin
    ptr_d = ptr_q;
    if (frame_start) begin
      ptr_d = '0;
    end else if (pick_found) begin
      ptr_d = (pick_idx == PTR_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
    end

    rom_en_d   = pick_found;
    rom_addr_d = rom_addr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        rom_addr_d = addr[i*ADDR_W +: ADDR_W];
      end
    end

    tag_d = {tag_q[ROM_LAT-1:0], pick_gnt};

    rvalid_d = tag_q[ROM_LAT];
    rdata_d  = (|tag_q[ROM_LAT]) ? rom_data : rdata_q;

    conflict = (req & (req - 1'b1)) != '0;
    run_inc  = (conflict && (run_q != 16'hFFFF)) ? run_q + 16'd1 : run_q;
    if (frame_start) begin
      stat_d = run_inc;
      run_d  = '0;
    end else begin
      stat_d = stat_q;
      run_d  = run_inc;
    end
  end

  // All state registers; reset discards in-flight tags so stale reads never return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      tag_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= DATA_W'(BLACK);
      run_q      <= '0;
      stat_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      tag_q      <= tag_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      run_q      <= run_d;
      stat_q     <= stat_d;
    end
  end

  assign rom_en         = rom_en_q;
  assign rom_addr       = rom_addr_q;
  assign rvalid         = rvalid_q;
  assign rdata          = rdata_q;
  assign stat_conflicts = stat_q;

endmodule
